data_access_unit: RTL and testbench

DATA_ACCESS_UNIT -- requirements
Module: data_access_unit

---
 rtl/da_pkg.sv | 14 +
 rtl/da_lane_mux.sv | 24 ++
 rtl/data_access_unit.sv | 108 ++++++++++
 tb/tb_data_access_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// Shared constants and FSM state type for the data access unit.
package da_pkg;

  localparam int W     = 32;
  localparam int V     = 128;
  localparam int BEATS = V / W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } da_state_t;

endpackage

// File: rtl/da_lane_mux.sv
// Selects one W-bit word lane out of a V-bit vector, lane 0 in the low bits.
module da_lane_mux #(
  parameter int W  = 32,
  parameter int V  = 128,
  parameter int CW = 2
) (
  input  logic [V-1:0]  data_i,
  input  logic [CW-1:0] sel_i,
  output logic [W-1:0]  data_o
);

  localparam int NB = V / W;

  logic [W-1:0] lanes [NB];

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign lanes[gi] = data_i[gi*W +: W];
    end
  endgenerate

  assign data_o = lanes[sel_i];

endmodule

// File: rtl/data_access_unit.sv
// M-stage load/store engine: splits scalar or vector accesses into W-bit
// memory beats and stalls the pipeline through BusyDA until the last beat lands.
module data_access_unit #(
  parameter int W = da_pkg::W,
  parameter int V = da_pkg::V
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         MemReadM,
  input  logic         MemWriteM,
  input  logic         VectorM,
  input  logic [W-1:0] ALUResultM,
  input  logic [W-1:0] WriteDataM,
  input  logic [V-1:0] WriteDataVM,
  output logic [W-1:0] ReadDataM,
  output logic [V-1:0] ReadDataVM,
  output logic         BusyDA,
  output logic         mem_req,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  input  logic         mem_ack
);

  import da_pkg::*;

  localparam int NB = V / W;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  da_state_t     state_q;
  logic [CW-1:0] beat_q;
  logic [W-1:0]  base_q;
  logic [W-1:0]  wdata_q;
  logic [V-1:0]  wdatav_q;
  logic [W-1:0]  rdata_q;
  logic [V-1:0]  rdatav_q;
  logic          we_q;
  logic          vec_q;

  logic          req;
  logic          last_beat;
  logic [W-1:0]  lane_data;

  assign req       = MemReadM | MemWriteM;
  assign last_beat = !vec_q || (beat_q == CW'(NB - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      base_q   <= '0;
      wdata_q  <= '0;
      wdatav_q <= '0;
      rdata_q  <= '0;
      rdatav_q <= '0;
      we_q     <= 1'b0;
      vec_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            // A simultaneous read+write request is treated as a store.
            base_q   <= VectorM ? (ALUResultM & ~W'(32'hF)) : (ALUResultM & ~W'(32'h3));
            we_q     <= MemWriteM;
            vec_q    <= VectorM;
            wdata_q  <= WriteDataM;
            wdatav_q <= WriteDataVM;
            beat_q   <= '0;
            state_q  <= XFER;
          end
        end
        XFER: begin
          if (mem_ack) begin
            if (!we_q) begin
              if (vec_q) rdatav_q[int'(beat_q)*W +: W] <= mem_rdata;
              else       rdata_q <= mem_rdata;
            end
            if (last_beat) state_q <= DONE;
            else           beat_q  <= beat_q + CW'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  da_lane_mux #(
    .W  (W),
    .V  (V),
    .CW (CW)
  ) u_lane_mux (
    .data_i (wdatav_q),
    .sel_i  (beat_q),
    .data_o (lane_data)
  );

  // Reset gates the handshake outputs immediately so an abandoned access issues nothing.
  assign mem_req    = !rst && (state_q == XFER);
  assign BusyDA     = !rst && ((state_q == XFER) || ((state_q == IDLE) && req));
  assign mem_we     = mem_req && we_q;
  assign mem_addr   = base_q + (W'(beat_q) << 2);
  assign mem_wdata  = vec_q ? lane_data : wdata_q;
  assign ReadDataM  = rdata_q;
  assign ReadDataVM = rdatav_q;

endmodule

// File: tb/tb_data_access_unit.sv
// Scoreboard bench for data_access_unit: expected beats are queued when an
// access is driven and retired as the DUT completes them against a memory model.
module tb_data_access_unit;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         MemReadM, MemWriteM, VectorM;
  logic [31:0]  ALUResultM, WriteDataM;
  logic [127:0] WriteDataVM;
  logic [31:0]  ReadDataM;
  logic [127:0] ReadDataVM;
  logic         BusyDA, mem_req, mem_we;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic         mem_ack;

  logic [31:0]  mem [256];
  beat_t        sb [$];
  logic [31:0]  exp_rd;
  logic [127:0] exp_rdv;
  int           checks = 0;
  int           failures = 0;

  data_access_unit #(.W(32), .V(128)) dut (
    .clk         (clk),
    .rst         (rst),
    .MemReadM    (MemReadM),
    .MemWriteM   (MemWriteM),
    .VectorM     (VectorM),
    .ALUResultM  (ALUResultM),
    .WriteDataM  (WriteDataM),
    .WriteDataVM (WriteDataVM),
    .ReadDataM   (ReadDataM),
    .ReadDataVM  (ReadDataVM),
    .BusyDA      (BusyDA),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (!rst && mem_req && mem_ack && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_access(input logic rd, input logic wr, input logic vec,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [127:0] wdv,
                            input int s0, input int s1, input int s2, input int s3,
                            input int exp_busy, input string name);
    int          st [4];
    int          nb, bi, sl, busy;
    logic        done;
    logic [31:0] base;
    beat_t       e;
    st[0] = s0; st[1] = s1; st[2] = s2; st[3] = s3;
    nb   = vec ? 4 : 1;
    base = vec ? (addr & 32'hFFFF_FFF0) : (addr & 32'hFFFF_FFFC);
    for (int i = 0; i < nb; i++) begin
      e.we   = wr;
      e.addr = base + 32'(4 * i);
      e.data = vec ? wdv[32*i +: 32] : wd;
      sb.push_back(e);
      if (!wr) begin
        if (vec) exp_rdv[32*i +: 32] = mem[e.addr[9:2]];
        else     exp_rd = mem[e.addr[9:2]];
      end
    end
    MemReadM = rd; MemWriteM = wr; VectorM = vec;
    ALUResultM = addr; WriteDataM = wd; WriteDataVM = wdv;
    bi = 0; sl = st[0]; busy = 0; done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      mem_ack = (sl == 0);
      @(negedge clk);
      if (BusyDA) busy++;
      if (mem_req) begin
        chk({name, "_beat_expected"}, 128'(sb.size() != 0), 128'(1));
        if (sb.size() != 0) begin
          e = sb[0];
          chk({name, "_addr"}, 128'(mem_addr), 128'(e.addr));
          chk({name, "_we"}, 128'(mem_we), 128'(e.we));
          if (e.we) chk({name, "_wdata"}, 128'(mem_wdata), 128'(e.data));
          if (mem_ack) begin
            void'(sb.pop_front());
            bi++;
            sl = (bi < 4) ? st[bi] : 0;
          end else begin
            sl--;
          end
        end
      end else if (cyc > 0 && !BusyDA) begin
        done = 1'b1;
        chk({name, "_we_idle"}, 128'(mem_we), 128'(0));
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    chk({name, "_done_seen"}, 128'(done), 128'(1));
    chk({name, "_busy_cycles"}, 128'(busy), 128'(exp_busy));
    chk({name, "_sb_drained"}, 128'(sb.size()), 128'(0));
    chk({name, "_rdata"}, 128'(ReadDataM), 128'(exp_rd));
    chk({name, "_rdatav"}, ReadDataVM, exp_rdv);
    $display("txn %s addr=%08h rd=%0b wr=%0b vec=%0b busy=%0d rdata=%08h rdatav=%032h",
             name, addr, rd, wr, vec, busy, ReadDataM, ReadDataVM);
    sb.delete();
    @(posedge clk); #1;
    MemReadM = 1'b0; MemWriteM = 1'b0; VectorM = 1'b0; mem_ack = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic found;
    for (int i = 0; i < 256; i++) mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    mem[8'h40] = 32'hDEAD_BEEF;
    rst = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; VectorM = 1'b0;
    ALUResultM = '0; WriteDataM = '0; WriteDataVM = '0; mem_ack = 1'b1;
    exp_rd = '0; exp_rdv = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(BusyDA), 128'(0));
    chk("rst_req", 128'(mem_req), 128'(0));
    chk("rst_we", 128'(mem_we), 128'(0));
    chk("rst_rdata", 128'(ReadDataM), 128'(0));
    chk("rst_rdatav", ReadDataVM, 128'(0));
    @(posedge clk); #1;
    rst = 1'b0; MemReadM = 1'b0;
    @(negedge clk);
    chk("idle_busy", 128'(BusyDA), 128'(0));
    chk("idle_req", 128'(mem_req), 128'(0));
    @(posedge clk); #1;

    run_access(1, 0, 0, 32'h0000_0103, 32'h0, 128'h0, 0, 0, 0, 0, 2, "ld_scalar_103");
    run_access(0, 1, 1, 32'h0000_0020, 32'h0,
               128'h00112233_44556677_8899AABB_CCDDEEFF, 0, 0, 0, 0, 5, "st_vec_20");
    run_access(1, 0, 1, 32'h0000_0040, 32'h0, 128'h0, 0, 2, 0, 2, 9, "ld_vec_40_stall");
    run_access(1, 1, 0, 32'h0000_0008, 32'h1234_5678, 128'h0, 0, 0, 0, 0, 2, "rdwr_scalar_8");
    run_access(1, 0, 0, 32'h0000_0009, 32'h0, 128'h0, 1, 0, 0, 0, 3, "ld_scalar_9");
    run_access(1, 0, 0, 32'h0000_0010, 32'h0, 128'h0, 0, 0, 0, 0, 2, "ld_b2b_10");
    run_access(1, 0, 0, 32'h0000_0014, 32'h0, 128'h0, 0, 0, 0, 0, 2, "ld_b2b_14");
    run_access(1, 0, 1, 32'h0000_002C, 32'h0, 128'h0, 0, 0, 0, 0, 5, "ld_vec_2c");
    chk("vec_roundtrip", ReadDataVM, 128'h00112233_44556677_8899AABB_CCDDEEFF);

    // Reset while the third beat of a vector load is pending.
    MemReadM = 1'b1; VectorM = 1'b1; ALUResultM = 32'h0000_0040; mem_ack = 1'b1;
    found = 1'b0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 32'h0000_0048) begin
        found = 1'b1;
        mem_ack = 1'b0;
        rst = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("rstx_beat2_seen", 128'(found), 128'(1));
    @(posedge clk); #1;
    rst = 1'b0; MemReadM = 1'b0; VectorM = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    chk("rstx_req", 128'(mem_req), 128'(0));
    chk("rstx_busy", 128'(BusyDA), 128'(0));
    chk("rstx_rdatav", ReadDataVM, 128'(0));
    chk("rstx_rdata", 128'(ReadDataM), 128'(0));
    $display("txn rst_mid_xfer req=%0b busy=%0b rdatav=%032h", mem_req, BusyDA, ReadDataVM);
    exp_rd = '0; exp_rdv = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstx_no_beat", 128'(mem_req), 128'(0));
    end
    @(posedge clk); #1;

    run_access(1, 0, 0, 32'h0000_0100, 32'h0, 128'h0, 0, 0, 0, 0, 2, "ld_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
